lcd_bus_rx: RTL
===============

# lcd_bus_rx

HD44780-compatible bus responder: the display end of the 8-bit parallel LCD bus driven by the team's LCD controller. It samples RS/RW/E/DATA, decodes commands and data writes, and keeps a 2×16 shadow DDRAM, address counter and display flags. It can answer busy-flag and data reads. It sits on-chip beside the panel pins as a capture mirror for a debug/UART dump and for self-checking benches.

## Interface
Parameters:
- `EXEC_CYCLES`, 2000 — busy duration for normal commands and data writes (40 µs @ 50 MHz).
- `CLEAR_CYCLES`, 76500 — busy duration for clear and return-home (1.53 ms).
- `MIN_E_HIGH`, 12 — minimum synchronized E-high width in cycles. Shorter pulses are rejected.

Ports:
- `clk` in 1 — system clock, 50 MHz. This is the only clock.
- `rst` in 1 — reset, synchronous and active-high.
- `i_lcd_rs`, `i_lcd_rw`, `i_lcd_e` in 1 — bus control from the LCD controller.
- `i_lcd_data` in 8 — bus data.
- `o_lcd_dout` out 8 — read-back data.
- `o_lcd_doe` out 1 — read-back drive enable.
- `i_rd_addr` in 5 — shadow read index. 0–15 is line 1; 16–31 is line 2.
- `o_rd_data` out 8 — registered shadow byte at `i_rd_addr`.
- `o_ac` out 7 — address counter.
- `o_disp_on`, `o_cursor_on`, `o_blink_on` out 1 — display-control bits.
- `o_busy` out 1 — modelled busy flag.
- `o_wr_strobe` out 1 — 1-cycle pulse per accepted command or data write.
- `o_err` out 1 — 1-cycle pulse per protocol violation.

## Operation
**Reset values**
- Shadow: all 0x20.
- `o_ac`=0, I/D=1.
- `o_disp_on`/`o_cursor_on`/`o_blink_on`=0.
- `o_busy`=0, `o_lcd_doe`=0, `o_lcd_dout`=0x00, `o_rd_data`=0x00, strobes=0.
- FSM=S_IDLE.
- `rst` mid-operation aborts any clear fill or busy countdown.

**Input capture**
- All bus inputs pass through a 2-flop synchronizer.
- RS/RW/DATA use the sample aligned with the last synchronized E-high cycle.
- The E-high width counter saturates.

**Falling edge of E**
- Width < `MIN_E_HIGH`: the access is ignored and `o_err` pulses.
- Otherwise the access is decoded.

**Write commands (RS=0, RW=0)**, decoded by highest set bit:
- 1aaaaaaa: AC=a.
- 01xxxxxx (CGRAM address): accepted, no state change.
- 001xxxxx (function set): accepted, no state change.
- 0001 S/C R/L xx:
  - S/C=0: AC steps +1 if R/L=1, −1 if R/L=0.
  - S/C=1: accepted, no effect.
- 00001DCB: `o_disp_on`=D, `o_cursor_on`=C, `o_blink_on`=B.
- 000001 I/D S: stores I/D; S is ignored.
- 0000001x: AC=0. Busy for `CLEAR_CYCLES`.
- 00000001: state S_CLEAR writes 0x20 to indices 0..31, one per cycle (32 cycles). Sets AC=0, I/D=1. Busy for `CLEAR_CYCLES` total, counted from acceptance.
- 0x00: no-op. No strobe, no busy.

**Data write (RS=1, RW=0)**
- AC 0x00–0x0F maps to index AC; AC 0x40–0x4F maps to index AC−0x30.
- Unmapped AC: the byte is dropped but AC still steps.
- AC steps per I/D.

**AC stepping (2-line wrap)**
- Increment: 0x27→0x40, 0x67→0x00.
- Decrement: 0x40→0x27, 0x00→0x67.

**Reads (RW=1)**
- Allowed even when busy.
- While synchronized E is high, `o_lcd_doe`=1.
  - RS=0: `o_lcd_dout`={busy, AC}.
  - RS=1: `o_lcd_dout`=shadow[AC], or 0x20 if unmapped. AC steps on the falling edge.
- `o_lcd_doe` drops the cycle after E is seen low.

**FSM**
- S_IDLE → S_DECODE on an accepted edge.
- S_DECODE → S_CLEAR (clear command) or S_BUSY (other accepted writes).
- S_CLEAR → S_BUSY after index 31.
- S_BUSY → S_IDLE when the countdown hits 0.

## Timing
- E falling edge at pin to edge detect: 3 cycles.
- Shadow/AC/flags update, and `o_wr_strobe`, occur 1 cycle after edge detect.
- `o_busy` rises in the strobe cycle and stays high exactly `EXEC_CYCLES` or `CLEAR_CYCLES` cycles.
- `o_rd_data`: 1-cycle latency. A same-cycle write to the same index returns the old value. Reads during S_CLEAR return current contents.
- Read data is valid on `o_lcd_dout` 3 cycles after the E rise at the pin.

## Configuration
**`LCD_BUS_RX_BUSY_EN`**
- Defined: busy is modelled as above.
  - A write whose edge arrives while `o_busy`=1 is dropped.
  - `o_err` pulses and `o_wr_strobe` stays low.
  - The busy countdown is not restarted.
- Undefined:
  - `o_busy` is tied 0 and no write is ever dropped for busy.
  - Clear still takes 32 fill cycles; an edge during S_CLEAR is queued one-deep and decoded after the fill.
  - The read-back busy bit is 0.

## Test plan
1. Init 0x38, 0x0C, 0x06, 0x01, 0x80 with 51-cycle E pulses, 2500-cycle gaps and 100000 after clear → `o_disp_on`=1, cursor/blink=0, AC=0, indices 0–31 read 0x20, no `o_err`.
2. 0x80 + 16×0x4F, then 0xC0 + 16×0x20 → indices 0–15 read 0x4F, 16–31 read 0x20, final AC=0x50, 34 strobes.
3. 0xA7 then data 0x41, 0x42 → index 16 reads 0x42, AC=0x41; 0x41 dropped (0x27 unmapped), no `o_err`.
4. Decrement wrap: 0x04, then 0x80, then 0x10 → AC=0x67.
5. `LCD_BUS_RX_BUSY_EN`: 0x01, then data 0x55 edge 100 cycles later → 1-cycle `o_err`, shadow unchanged, `o_busy` high 76500 cycles.
6. 5-cycle E pulse with 0x01 → `o_err`, shadow untouched. Read RS=0 after 0xC5 → `o_lcd_doe`=1, `o_lcd_dout`=0xC5 while busy, 0x45 after busy.

Source files
------------

// File: rtl/lcd_bus_rx.sv
// HD44780-style bus responder: captures RS/RW/E/DATA, keeps a 2x16 shadow DDRAM,
// address counter and display flags, and answers busy/data reads.
// Optional busy modelling and write-drop are enabled with `LCD_BUS_RX_BUSY_EN.
module lcd_bus_rx #(
  parameter int unsigned EXEC_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 76500,
  parameter int unsigned MIN_E_HIGH   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_lcd_rs,
  input  logic       i_lcd_rw,
  input  logic       i_lcd_e,
  input  logic [7:0] i_lcd_data,
  output logic [7:0] o_lcd_dout,
  output logic       o_lcd_doe,
  input  logic [4:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic [6:0] o_ac,
  output logic       o_disp_on,
  output logic       o_cursor_on,
  output logic       o_blink_on,
  output logic       o_busy,
  output logic       o_wr_strobe,
  output logic       o_err
);

  localparam int unsigned MAX_CYC = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES : EXEC_CYCLES;
  localparam int unsigned BCNT_W  = $clog2(MAX_CYC + 1);
  localparam int unsigned WCNT_W  = $clog2(MIN_E_HIGH + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_CLEAR, S_BUSY} state_t;

  state_t              state;
  logic [1:0]          rs_sync, rw_sync, e_sync;
  logic [7:0]          data_sync0, data_sync1;
  logic                e_prev;
  logic [WCNT_W-1:0]   e_width;
  logic                cap_rs, cap_rw;
  logic [7:0]          cap_data;
  logic                dec_rs, dec_rw;
  logic [7:0]          dec_data;
  logic                pend_v, pend_rs, pend_rw;
  logic [7:0]          pend_data;
  logic [7:0]          shadow [32];
  logic                inc_dir;
  logic [4:0]          fill_idx;
  logic                busy_int;
  logic [BCNT_W-1:0]   busy_cnt;

  logic                fall_c, wide_c, drop_c, accept_c, busy_flag_c, busy_cont_c;
  logic [7:0]          rd_byte_c;

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h40) return 7'h27;
    if (a == 7'h00) return 7'h67;
    return a - 7'd1;
  endfunction

  // 0x00-0x0F and 0x40-0x4F are the only visible DDRAM addresses
  function automatic logic ac_mapped(input logic [6:0] a);
    return a[5:4] == 2'b00;
  endfunction

  function automatic logic [4:0] ac_idx(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

`ifdef LCD_BUS_RX_BUSY_EN
  assign busy_flag_c = busy_int;
`else
  assign busy_flag_c = 1'b0;
`endif
  assign o_busy      = busy_flag_c;

  assign fall_c      = e_prev & ~e_sync[1];
  assign wide_c      = e_width >= WCNT_W'(MIN_E_HIGH);
  assign drop_c      = fall_c & wide_c & ~cap_rw & busy_flag_c;
  assign accept_c    = fall_c & wide_c & ~drop_c;
  assign busy_cont_c = busy_int & (busy_cnt != '0);
  assign rd_byte_c   = ac_mapped(o_ac) ? shadow[ac_idx(o_ac)] : 8'h20;

  // Synchronizers, E-width counter and capture of the last E-high sample
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_sync    <= '0;
      rw_sync    <= '0;
      e_sync     <= '0;
      data_sync0 <= '0;
      data_sync1 <= '0;
      e_prev     <= 1'b0;
      e_width    <= '0;
      cap_rs     <= 1'b0;
      cap_rw     <= 1'b0;
      cap_data   <= '0;
    end else begin
      rs_sync    <= {rs_sync[0], i_lcd_rs};
      rw_sync    <= {rw_sync[0], i_lcd_rw};
      e_sync     <= {e_sync[0], i_lcd_e};
      data_sync0 <= i_lcd_data;
      data_sync1 <= data_sync0;
      e_prev     <= e_sync[1];
      if (e_sync[1]) begin
        if (e_width != '1) e_width <= e_width + WCNT_W'(1);
        cap_rs   <= rs_sync[1];
        cap_rw   <= rw_sync[1];
        cap_data <= data_sync1;
      end else begin
        e_width <= '0;
      end
    end
  end

  // Read-back drive and registered shadow port
  always_ff @(posedge clk) begin
    if (rst) begin
      o_lcd_doe  <= 1'b0;
      o_lcd_dout <= 8'h00;
      o_rd_data  <= 8'h00;
    end else begin
      o_lcd_doe <= e_sync[1] & rw_sync[1];
      if (e_sync[1] & rw_sync[1])
        o_lcd_dout <= rs_sync[1] ? rd_byte_c : {busy_flag_c, o_ac};
      o_rd_data <= shadow[i_rd_addr];
    end
  end

  // Access decode, clear fill and busy countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
      o_ac        <= '0;
      inc_dir     <= 1'b1;
      o_disp_on   <= 1'b0;
      o_cursor_on <= 1'b0;
      o_blink_on  <= 1'b0;
      busy_int    <= 1'b0;
      busy_cnt    <= '0;
      fill_idx    <= '0;
      pend_v      <= 1'b0;
      pend_rs     <= 1'b0;
      pend_rw     <= 1'b0;
      pend_data   <= '0;
      dec_rs      <= 1'b0;
      dec_rw      <= 1'b0;
      dec_data    <= '0;
      o_wr_strobe <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_wr_strobe <= 1'b0;
      o_err       <= (fall_c & ~wide_c) | drop_c;
      if (busy_int) begin
        if (busy_cnt == '0) busy_int <= 1'b0;
        else                busy_cnt <= busy_cnt - BCNT_W'(1);
      end

      case (state)
        S_IDLE, S_BUSY: begin
          if (accept_c) begin
            dec_rs   <= cap_rs;
            dec_rw   <= cap_rw;
            dec_data <= cap_data;
            state    <= S_DECODE;
          end else if (state == S_BUSY && !busy_cont_c) begin
            state <= S_IDLE;
          end
        end

        S_DECODE: begin
          state <= busy_cont_c ? S_BUSY : S_IDLE;
          if (!dec_rw && dec_rs) begin
            if (ac_mapped(o_ac)) shadow[ac_idx(o_ac)] <= dec_data;
            o_ac        <= ac_step(o_ac, inc_dir);
            o_wr_strobe <= 1'b1;
            busy_int    <= 1'b1;
            busy_cnt    <= BCNT_W'(EXEC_CYCLES - 1);
            state       <= S_BUSY;
          end else if (!dec_rw && dec_data != 8'h00) begin
            o_wr_strobe <= 1'b1;
            busy_int    <= 1'b1;
            busy_cnt    <= (dec_data[7:2] == 6'd0) ? BCNT_W'(CLEAR_CYCLES - 1)
                                                   : BCNT_W'(EXEC_CYCLES - 1);
            state       <= S_BUSY;
            if (dec_data[7]) begin
              o_ac <= dec_data[6:0];
            end else if (dec_data[6] || dec_data[5]) begin
              // CGRAM address and function set carry no modelled state
            end else if (dec_data[4]) begin
              if (!dec_data[3]) o_ac <= ac_step(o_ac, dec_data[2]);
            end else if (dec_data[3]) begin
              o_disp_on   <= dec_data[2];
              o_cursor_on <= dec_data[1];
              o_blink_on  <= dec_data[0];
            end else if (dec_data[2]) begin
              inc_dir <= dec_data[1];
            end else if (dec_data[1]) begin
              o_ac <= '0;
            end else begin
              o_ac     <= '0;
              inc_dir  <= 1'b1;
              fill_idx <= '0;
              state    <= S_CLEAR;
            end
          end else if (dec_rw && dec_rs) begin
            o_ac <= ac_step(o_ac, inc_dir);
          end
        end

        S_CLEAR: begin
          shadow[fill_idx] <= 8'h20;
          fill_idx         <= fill_idx + 5'd1;
          if (fill_idx == 5'd31) begin
            if (pend_v) begin
              dec_rs   <= pend_rs;
              dec_rw   <= pend_rw;
              dec_data <= pend_data;
              pend_v   <= 1'b0;
              state    <= S_DECODE;
              if (accept_c) o_err <= 1'b1;
            end else if (accept_c) begin
              dec_rs   <= cap_rs;
              dec_rw   <= cap_rw;
              dec_data <= cap_data;
              state    <= S_DECODE;
            end else begin
              state <= S_BUSY;
            end
          end else if (accept_c) begin
            // One-deep queue; a second access during the fill is a violation
            if (pend_v) begin
              o_err <= 1'b1;
            end else begin
              pend_v    <= 1'b1;
              pend_rs   <= cap_rs;
              pend_rw   <= cap_rw;
              pend_data <= cap_data;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
